dummy_tile_err_responder: RTL and testbench
===========================================

// Module: dummy_tile_err_responder
// PURPOSE
// Terminating responder on the narrow Eject port of a dummy tile router. Accepts narrow AW/W/AR
// flits routed to a tile with no endpoint and answers every transaction with DECERR (B, or R
// bursts of len+1 beats). Misrouted or probing transactions therefore complete instead of hanging
// the NoC. A thin wrapper packs and unpacks floo_req_t/floo_rsp_t onto these flattened ports.
// PARAMETERS
// IdWidth      6   width of NoC src/dst id fields
// AxiIdWidth   4   width of AXI transaction id
// DataWidth    64  width of R data field (driven all-zero)
// CntWidth     16  width of saturating error counter
// PORTS
// clk_i            in   1           clock
// rst_ni           in   1           asynchronous reset, active low
// req_valid_i      in   1           narrow request flit valid
// req_ready_o      out  1           narrow request flit ready
// req_ch_i         in   3           channel: 0=AW 1=W 2=AR (other values: invalid)
// req_src_id_i     in   IdWidth     source id of flit (becomes response dst)
// req_axi_id_i     in   AxiIdWidth  AXI id (AW/AR only)
// req_len_i        in   8           AXI len (AW/AR only)
// req_last_i       in   1           W last
// rsp_valid_o      out  1           response flit valid
// rsp_ready_i      in   1           response flit ready
// rsp_ch_o         out  3           3=B 4=R
// rsp_dst_id_o     out  IdWidth     destination id
// rsp_axi_id_o     out  AxiIdWidth  AXI id
// rsp_resp_o       out  2           always 2'b11 (DECERR) while valid
// rsp_data_o       out  DataWidth   always '0
// rsp_last_o       out  1           1 on B and on final R beat
// err_count_o      out  CntWidth    completed transactions, saturating
// BEHAVIOUR
// - Reset: state IDLE, AR-pending empty, beat counter 0, err_count_o=0, rsp_valid_o=0, req_ready_o=1.
// - FSM states: IDLE, W_DRAIN, B_SEND, R_SEND. Handshake = valid & ready on the same cycle.
// - IDLE: req_ready_o=1. AW -> latch src/axi_id, go W_DRAIN. AR -> latch src/axi_id/len, beat
//   counter=0, go R_SEND. W in IDLE is an orphan: consumed and dropped, stay IDLE. Invalid ch is
//   consumed and dropped.
// - W_DRAIN: W flits accepted. W with last=1 -> B_SEND next cycle. One AR may be accepted into a
//   single pending register (latches src/id/len); a second AR or any AW lowers req_ready_o
//   (combinational on flit ch) until W_DRAIN is left. W beats are never blocked by ARs.
// - B_SEND: req_ready_o=0; rsp_valid_o=1, ch=B, last=1. On handshake: err_count++. If AR pending,
//   load it, counter=0, go R_SEND; else IDLE.
// - R_SEND: req_ready_o=0; rsp_valid_o=1, ch=R, last=(counter==len). Each handshake counter++.
//   On the last-beat handshake: err_count++, go IDLE. Counter is 9 bit; len=255 gives 256 beats,
//   no wrap.
// - Response latency: first response flit valid 1 cycle after the accepting handshake (AR or W last).
// - rsp_* fields stay stable while rsp_valid_o=1 and rsp_ready_i=0; valid is never withdrawn.
// - err_count_o saturates at all-ones and never wraps.
// - Reset mid-burst: all state is cleared asynchronously, any pending AR is discarded and
//   rsp_valid_o drops immediately. No partial burst completes after reset release.
// - Outputs are registered from state. Only req_ready_o may depend combinationally on req_ch_i.
// TESTING
// 1. AW(src=5,id=3,len=0), W(last=1) -> one B: dst=5 id=3 resp=11 last=1; err_count=1.
// 2. AR(src=2,id=7,len=3), rsp_ready=1 -> 4 R beats on consecutive cycles, last only on beat 4,
//    data=0; then ready=1 in IDLE.
// 3. AW(len=1), W, AR(src=9,id=1,len=0), W(last) -> B for AW first, then 1 R for the AR.
//    A second AR offered during drain sees req_ready_o=0.
// 4. AR(len=255) with rsp_ready toggled randomly -> exactly 256 R handshakes, last on the 256th,
//    fields stable while stalled.
// 5. Reset asserted after R beat 2 of a len=7 burst -> rsp_valid_o=0 at once; after release
//    IDLE, req_ready_o=1, err_count=0.
// 6. CntWidth=2, 5 transactions -> err_count_o reads 1,2,3,3,3; orphan W in IDLE is dropped
//    with no response.

Source files
------------

// File: rtl/dummy_tile_err_responder.sv
// Terminating DECERR responder for the narrow eject port of a dummy tile.
// Every AW/W or AR flit that reaches it completes with a B or an R burst.
module dummy_tile_err_responder #(
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_ch_i,
  input  logic [IdWidth-1:0]    req_src_id_i,
  input  logic [AxiIdWidth-1:0] req_axi_id_i,
  input  logic [7:0]            req_len_i,
  input  logic                  req_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [2:0]            rsp_ch_o,
  output logic [IdWidth-1:0]    rsp_dst_id_o,
  output logic [AxiIdWidth-1:0] rsp_axi_id_o,
  output logic [1:0]            rsp_resp_o,
  output logic [DataWidth-1:0]  rsp_data_o,
  output logic                  rsp_last_o,
  output logic [CntWidth-1:0]   err_count_o
);

  localparam logic [2:0] CH_AW = 3'd0;
  localparam logic [2:0] CH_W  = 3'd1;
  localparam logic [2:0] CH_AR = 3'd2;
  localparam logic [2:0] CH_B  = 3'd3;
  localparam logic [2:0] CH_R  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    W_DRAIN,
    B_SEND,
    R_SEND
  } state_e;

  state_e                state_q, state_d;
  logic [IdWidth-1:0]    src_q, src_d;
  logic [AxiIdWidth-1:0] id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            beat_q, beat_d;
  logic                  pend_q, pend_d;
  logic [IdWidth-1:0]    pend_src_q, pend_src_d;
  logic [AxiIdWidth-1:0] pend_id_q, pend_id_d;
  logic [7:0]            pend_len_q, pend_len_d;
  logic [CntWidth-1:0]   err_q, err_d;

  logic req_hs;
  logic rsp_hs;
  logic last_beat;
  logic [CntWidth-1:0] err_inc;

  assign req_hs    = req_valid_i & req_ready_o;
  assign rsp_hs    = rsp_valid_o & rsp_ready_i;
  assign last_beat = (beat_q == {1'b0, len_q});
  assign err_inc   = (err_q == '1) ? err_q
                                   : err_q + CntWidth'(1);

  // W beats always pass while draining; only a
  // second AR or a new AW must wait.
  always_comb begin
    req_ready_o = 1'b0;
    unique case (state_q)
      IDLE: req_ready_o = 1'b1;
      W_DRAIN: begin
        unique case (1'b1)
          (req_ch_i == CH_AW): req_ready_o = 1'b0;
          (req_ch_i == CH_AR): req_ready_o = ~pend_q;
          default:             req_ready_o = 1'b1;
        endcase
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_d     = beat_q;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    pend_id_d  = pend_id_q;
    pend_len_d = pend_len_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs && req_ch_i == CH_AW) begin
          src_d   = req_src_id_i;
          id_d    = req_axi_id_i;
          state_d = W_DRAIN;
        end else if (req_hs && req_ch_i == CH_AR) begin
          src_d   = req_src_id_i;
          id_d    = req_axi_id_i;
          len_d   = req_len_i;
          beat_d  = '0;
          state_d = R_SEND;
        end
      end
      W_DRAIN: begin
        if (req_hs && req_ch_i == CH_W && req_last_i) begin
          state_d = B_SEND;
        end else if (req_hs && req_ch_i == CH_AR) begin
          pend_d     = 1'b1;
          pend_src_d = req_src_id_i;
          pend_id_d  = req_axi_id_i;
          pend_len_d = req_len_i;
        end
      end
      B_SEND: begin
        if (rsp_hs) begin
          err_d = err_inc;
          if (pend_q) begin
            src_d   = pend_src_q;
            id_d    = pend_id_q;
            len_d   = pend_len_q;
            pend_d  = 1'b0;
            beat_d  = '0;
            state_d = R_SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      R_SEND: begin
        if (rsp_hs) begin
          beat_d = beat_q + 9'd1;
          if (last_beat) begin
            err_d   = err_inc;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      src_q      <= '0;
      id_q       <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      pend_src_q <= '0;
      pend_id_q  <= '0;
      pend_len_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      id_q       <= id_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      pend_id_q  <= pend_id_d;
      pend_len_q <= pend_len_d;
      err_q      <= err_d;
    end
  end

  assign rsp_valid_o  = (state_q == B_SEND) |
                        (state_q == R_SEND);
  assign rsp_ch_o     = (state_q == R_SEND) ? CH_R : CH_B;
  assign rsp_dst_id_o = src_q;
  assign rsp_axi_id_o = id_q;
  assign rsp_resp_o   = rsp_valid_o ? 2'b11 : 2'b00;
  assign rsp_data_o   = '0;
  assign rsp_last_o   = (state_q == B_SEND) |
                        ((state_q == R_SEND) & last_beat);
  assign err_count_o  = err_q;

endmodule

// File: tb/tb_dummy_tile_err_responder.sv
// Randomised and directed bench for dummy_tile_err_responder,
// checked every cycle against a transaction-level response queue.
module tb_dummy_tile_err_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_ch = '0;
  logic [5:0]  req_src = '0;
  logic [3:0]  req_id = '0;
  logic [7:0]  req_len = '0;
  logic        req_last = 1'b0;
  logic        rsp_ready = 1'b0;

  logic        req_ready_o, rsp_valid_o, rsp_last_o;
  logic [2:0]  rsp_ch_o;
  logic [5:0]  rsp_dst_id_o;
  logic [3:0]  rsp_axi_id_o;
  logic [1:0]  rsp_resp_o;
  logic [63:0] rsp_data_o;
  logic [15:0] err_count_o;

  logic        rdy_s, val_s, last_s;
  logic [2:0]  ch_s;
  logic [5:0]  dst_s;
  logic [3:0]  id_s;
  logic [1:0]  resp_s;
  logic [63:0] data_s;
  logic [1:0]  err_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dummy_tile_err_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_ch_i(req_ch), .req_src_id_i(req_src),
    .req_axi_id_i(req_id), .req_len_i(req_len),
    .req_last_i(req_last),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_ch_o(rsp_ch_o), .rsp_dst_id_o(rsp_dst_id_o),
    .rsp_axi_id_o(rsp_axi_id_o), .rsp_resp_o(rsp_resp_o),
    .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
    .err_count_o(err_count_o)
  );

  dummy_tile_err_responder #(.CntWidth(2)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(rdy_s),
    .req_ch_i(req_ch), .req_src_id_i(req_src),
    .req_axi_id_i(req_id), .req_len_i(req_len),
    .req_last_i(req_last),
    .rsp_valid_o(val_s), .rsp_ready_i(rsp_ready),
    .rsp_ch_o(ch_s), .rsp_dst_id_o(dst_s),
    .rsp_axi_id_o(id_s), .rsp_resp_o(resp_s),
    .rsp_data_o(data_s), .rsp_last_o(last_s),
    .err_count_o(err_s)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: expected response flits in order, plus open AW / pending AR
  typedef struct packed {
    logic [2:0] ch;
    logic [5:0] dst;
    logic [3:0] id;
    logic       last;
  } flit_t;

  flit_t      exp_q[$];
  flit_t      f;
  bit         aw_open = 0;
  bit         pend = 0;
  logic [5:0] aw_src, p_src;
  logic [3:0] aw_id, p_id;
  int         p_len;
  int         ecnt = 0;
  bit         exp_rdy;

  task automatic push_r(input logic [5:0] s, input logic [3:0] i,
                        input int len);
    for (int b = 0; b <= len; b++)
      exp_q.push_back('{3'd4, s, i, (b == len)});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      aw_open = 0;
      pend = 0;
      ecnt = 0;
      chk("rst_valid", {63'd0, rsp_valid_o}, 0);
      chk("rst_ready", {63'd0, req_ready_o}, 1);
      chk("rst_err", {48'd0, err_count_o}, 0);
      chk("rst_err_s", {62'd0, err_s}, 0);
    end else begin
      if (exp_q.size() != 0) exp_rdy = 0;
      else if (aw_open && req_ch == 3'd0) exp_rdy = 0;
      else if (aw_open && req_ch == 3'd2) exp_rdy = !pend;
      else exp_rdy = 1;
      chk("req_ready", {63'd0, req_ready_o}, {63'd0, exp_rdy});
      chk("req_ready_s", {63'd0, rdy_s}, {63'd0, exp_rdy});
      chk("rsp_valid", {63'd0, rsp_valid_o},
          {63'd0, exp_q.size() != 0});
      chk("rsp_valid_s", {63'd0, val_s},
          {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        f = exp_q[0];
        chk("rsp_ch", {61'd0, rsp_ch_o}, {61'd0, f.ch});
        chk("rsp_dst", {58'd0, rsp_dst_id_o}, {58'd0, f.dst});
        chk("rsp_id", {60'd0, rsp_axi_id_o}, {60'd0, f.id});
        chk("rsp_last", {63'd0, rsp_last_o}, {63'd0, f.last});
        chk("rsp_resp", {62'd0, rsp_resp_o}, 3);
        chk("rsp_data", rsp_data_o, 0);
        chk("rsp_ch_s", {61'd0, ch_s}, {61'd0, f.ch});
        chk("rsp_dst_s", {58'd0, dst_s}, {58'd0, f.dst});
        chk("rsp_id_s", {60'd0, id_s}, {60'd0, f.id});
        chk("rsp_last_s", {63'd0, last_s}, {63'd0, f.last});
        chk("rsp_resp_s", {62'd0, resp_s}, 3);
        chk("rsp_data_s", data_s, 0);
      end
      chk("err_count", {48'd0, err_count_o},
          (ecnt > 65535) ? 65535 : ecnt);
      chk("err_count_s", {62'd0, err_s}, (ecnt > 3) ? 3 : ecnt);
      if (rsp_valid_o && rsp_ready && exp_q.size() != 0) begin
        if (exp_q[0].last) ecnt++;
        void'(exp_q.pop_front());
      end
      if (req_valid && req_ready_o) begin
        if (req_ch == 3'd0 && !aw_open) begin
          aw_open = 1;
          aw_src = req_src;
          aw_id = req_id;
        end else if (req_ch == 3'd1 && aw_open && req_last) begin
          exp_q.push_back('{3'd3, aw_src, aw_id, 1'b1});
          if (pend) push_r(p_src, p_id, p_len);
          pend = 0;
          aw_open = 0;
        end else if (req_ch == 3'd2 && aw_open) begin
          pend = 1;
          p_src = req_src;
          p_id = req_id;
          p_len = int'(req_len);
        end else if (req_ch == 3'd2) begin
          push_r(req_src, req_id, int'(req_len));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] ch, input logic [5:0] s,
                      input logic [3:0] i, input logic [7:0] len,
                      input logic last);
    bit done = 0;
    req_valid = 1;
    req_ch = ch;
    req_src = s;
    req_id = i;
    req_len = len;
    req_last = last;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (req_ready_o) done = 1;
      tick();
    end
    req_valid = 0;
    chk("send_hs", {63'd0, done}, 1);
  endtask

  int beats;
  bit got_last;
  int sat_exp[5] = '{1, 2, 3, 3, 3};
  int r;

  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rsp_ready = 1;

    // 1: AW + W(last) -> one B
    send(3'd0, 6'd5, 4'd3, 8'd0, 1'b0);
    send(3'd1, 6'd0, 4'd0, 8'd0, 1'b1);
    @(negedge clk);
    chk("t1_valid", {63'd0, rsp_valid_o}, 1);
    chk("t1_ch", {61'd0, rsp_ch_o}, 3);
    chk("t1_dst", {58'd0, rsp_dst_id_o}, 5);
    chk("t1_id", {60'd0, rsp_axi_id_o}, 3);
    chk("t1_last", {63'd0, rsp_last_o}, 1);
    tick();
    @(negedge clk);
    chk("t1_err", {48'd0, err_count_o}, 1);
    tick();

    // 2: AR len=3 -> 4 consecutive R beats
    send(3'd2, 6'd2, 4'd7, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_valid", {63'd0, rsp_valid_o}, 1);
      chk("t2_last", {63'd0, rsp_last_o}, (i == 3) ? 1 : 0);
      chk("t2_dst", {58'd0, rsp_dst_id_o}, 2);
      tick();
    end
    @(negedge clk);
    chk("t2_ready", {63'd0, req_ready_o}, 1);
    chk("t2_err", {48'd0, err_count_o}, 2);
    tick();

    // 3: AR parked behind an AW drain, second AR blocked
    send(3'd0, 6'd4, 4'd2, 8'd1, 1'b0);
    send(3'd1, 6'd0, 4'd0, 8'd0, 1'b0);
    send(3'd2, 6'd9, 4'd1, 8'd0, 1'b0);
    req_valid = 1;
    req_ch = 3'd2;
    @(negedge clk);
    chk("t3_ar2_ready", {63'd0, req_ready_o}, 0);
    tick();
    req_valid = 0;
    send(3'd1, 6'd0, 4'd0, 8'd0, 1'b1);
    @(negedge clk);
    chk("t3_b_ch", {61'd0, rsp_ch_o}, 3);
    chk("t3_b_dst", {58'd0, rsp_dst_id_o}, 4);
    tick();
    @(negedge clk);
    chk("t3_r_ch", {61'd0, rsp_ch_o}, 4);
    chk("t3_r_dst", {58'd0, rsp_dst_id_o}, 9);
    chk("t3_r_id", {60'd0, rsp_axi_id_o}, 1);
    chk("t3_r_last", {63'd0, rsp_last_o}, 1);
    tick();
    @(negedge clk);
    chk("t3_err", {48'd0, err_count_o}, 4);
    tick();

    // 4: AR len=255 under random back-pressure
    send(3'd2, 6'd3, 4'd5, 8'd255, 1'b0);
    beats = 0;
    got_last = 0;
    for (int k = 0; k < 3000 && !got_last; k++) begin
      rsp_ready = 1'($urandom);
      @(negedge clk);
      if (rsp_valid_o && rsp_ready) begin
        beats++;
        if (rsp_last_o) got_last = 1;
      end
      tick();
    end
    rsp_ready = 1;
    chk("t4_beats", beats, 256);
    chk("t4_last_seen", {63'd0, got_last}, 1);

    // 5: reset in the middle of an 8-beat burst
    send(3'd2, 6'd1, 4'd2, 8'd7, 1'b0);
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("t5_valid_now", {63'd0, rsp_valid_o}, 0);
    repeat (3) tick();
    rst_n = 1;
    @(negedge clk);
    chk("t5_ready", {63'd0, req_ready_o}, 1);
    chk("t5_err", {48'd0, err_count_o}, 0);
    chk("t5_valid", {63'd0, rsp_valid_o}, 0);
    tick();

    // 6: orphan W dropped, then saturation on the 2-bit counter
    send(3'd1, 6'd7, 4'd0, 8'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("t6_orphan", {63'd0, rsp_valid_o}, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) begin
        send(3'd2, 6'(k), 4'(k), 8'd0, 1'b0);
      end else begin
        send(3'd0, 6'(k), 4'(k), 8'd0, 1'b0);
        send(3'd1, 6'd0, 4'd0, 8'd0, 1'b1);
      end
      tick();
      @(negedge clk);
      chk("t6_sat", {62'd0, err_s}, sat_exp[k]);
      chk("t6_full", {48'd0, err_count_o}, k + 1);
      tick();
    end

    // random traffic
    for (int c = 0; c < 5000; c++) begin
      if (c == 2500) begin
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
      end
      r = int'($urandom_range(0, 15));
      req_valid = ($urandom_range(0, 3) != 0);
      req_ch = (r < 5) ? 3'd0 : (r < 12) ? 3'd1 :
               (r < 15) ? 3'd2 : 3'($urandom_range(3, 7));
      req_src = 6'($urandom);
      req_id = 4'($urandom);
      req_len = ($urandom_range(0, 31) == 0) ? 8'($urandom)
                                              : 8'($urandom_range(0, 7));
      req_last = ($urandom_range(0, 2) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 0;
    rsp_ready = 1;
    for (int k = 0; k < 600 && exp_q.size() != 0; k++) tick();
    chk("drain", {63'd0, exp_q.size() == 0}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
